instmem_responder: RTL and testbench

INSTMEM_RESPONDER -- requirements
Module: instmem_responder

---
 rtl/instmem_responder_pkg.sv | 29 ++
 rtl/instmem_responder_mem_byte_array.sv | 27 ++
 rtl/instmem_responder.sv | 107 ++++++++++
 tb/tb_instmem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/instmem_responder_pkg.sv
// Shared sizes, FSM encoding and request bundle for instmem_responder.
// Block geometry is fixed here; the top only picks latency and depth.
package instmem_responder_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int BLOCK_SIZE = 128;
  localparam int BEATS      = BLOCK_SIZE / WORD_SIZE;
  localparam int BEAT_W     = $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [WORD_SIZE-1:0]  base;
    logic [BLOCK_SIZE-1:0] wdata;
  } req_t;

  function automatic logic [WORD_SIZE-1:0] align(
    input logic [WORD_SIZE-1:0] a
  );
    return a & ~WORD_SIZE'(BEATS - 1);
  endfunction

endpackage

// File: rtl/instmem_responder_mem_byte_array.sv
// Byte storage: one port, synchronous write, combinational read.
// Powers up with byte n = n[7:0]; has no reset.
module mem_byte_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Cells hold the difference from the power-up pattern, so a
  // zero initial image reads back as byte n = n.
  logic [WIDTH-1:0] delta [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      delta[addr] <= wdata ^ WIDTH'(addr);
    end
  end

  assign rdata = delta[addr] ^ WIDTH'(addr);

endmodule

// File: rtl/instmem_responder.sv
// Block-level instruction memory responder with fixed access latency.
// Define INSTMEM_WRITE_EN to compile in the block write path.
module instmem_responder
  import instmem_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [WORD_SIZE-1:0]  addr,
  input  logic [BLOCK_SIZE-1:0] wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BLOCK_SIZE-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t               state;
  req_t                 cur;
  logic [LW-1:0]        wait_cnt;
  logic [BEAT_W-1:0]    beat;
  logic [AW-1:0]        maddr;
  logic                 we;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

`ifndef INSTMEM_WRITE_EN
  logic unused_wr;
  assign unused_wr = ^{req_write, wdata};
`endif

  assign req_ready = (state == S_IDLE);
  assign maddr     = AW'(cur.base) + AW'(beat);
  assign mem_wdata = cur.wdata[WORD_SIZE*int'(beat) +: WORD_SIZE];
  // A reset edge must not commit the beat it lands on.
  assign we        = cur.write && (state == S_FILL) && !rst;

  mem_byte_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (maddr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      wait_cnt   <= '0;
      beat       <= '0;
      resp_valid <= 1'b0;
      rdata      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            cur.base <= align(addr);
`ifdef INSTMEM_WRITE_EN
            cur.write <= req_write;
            cur.wdata <= wdata;
`else
            cur.write <= 1'b0;
            cur.wdata <= '0;
`endif
            wait_cnt <= '0;
            beat     <= '0;
            state    <= (LATENCY == 0) ? S_FILL : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == LW'(LATENCY - 1)) begin
            state <= S_FILL;
          end else begin
            wait_cnt <= wait_cnt + LW'(1);
          end
        end
        S_FILL: begin
          rdata[WORD_SIZE*int'(beat) +: WORD_SIZE] <=
            cur.write ? mem_wdata : mem_rdata;
          beat <= beat + BEAT_W'(1);
          if (beat == BEAT_W'(BEATS - 1)) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instmem_responder.sv
// Bench for instmem_responder: vector table, hand sequences for
// reset abort and zero latency, then random traffic vs a byte model.
module tb_instmem_responder;
  import instmem_responder_pkg::*;

`ifdef INSTMEM_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif
  localparam int LAT = 4;

  logic clk;
  logic rst;
  logic req_valid, req_ready, req_write;
  logic [7:0] addr;
  logic [127:0] wdata, rdata;
  logic resp_valid, resp_ready;

  logic req_valid0, req_ready0, req_write0;
  logic [7:0] addr0;
  logic [127:0] wdata0, rdata0;
  logic resp_valid0, resp_ready0;

  int tests;
  int fails;
  logic [7:0] mem_m [256];

  instmem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .rdata(rdata)
  );

  instmem_responder #(.LATENCY(0), .DEPTH(256)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .addr(addr0), .wdata(wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .rdata(rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [127:0] got,
                       input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask

  function automatic logic [127:0] seqblk(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [127:0] model_blk(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = mem_m[8'(base + 8'(i))];
    return r;
  endfunction

  // Reference behaviour of one access: returns the expected block
  // and applies any write to the model.
  function automatic logic [127:0] model_access(input bit w,
    input logic [7:0] a, input logic [127:0] d);
    logic [7:0] base;
    base = a & 8'hF0;
    if (w && WR_EN) begin
      for (int i = 0; i < 16; i++) mem_m[base + 8'(i)] = d[8*i +: 8];
      return d;
    end
    return model_blk(base);
  endfunction

  task automatic access(input string tag, input bit w,
                        input logic [7:0] a, input logic [127:0] d,
                        input int hold, input logic [127:0] exp);
    int cyc;
    bit busy_ok;
    bit stable;
    logic [127:0] snap;
    check({tag, " ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_write = w;
    addr = a;
    wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!resp_valid && cyc < 100) begin
      if (req_ready) busy_ok = 1'b0;
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      addr = 8'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'(LAT + 16 + 1));
    check({tag, " busy"}, 128'(busy_ok), 128'(1));
    check({tag, " data"}, rdata, exp);
    snap = rdata;
    stable = 1'b1;
    repeat (hold) begin
      req_valid = 1'($urandom);
      addr = 8'($urandom);
      @(posedge clk); #1;
      if (!resp_valid || rdata !== snap || req_ready) stable = 1'b0;
    end
    check({tag, " hold"}, 128'(stable), 128'(1));
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " release"}, 128'({req_ready, resp_valid}), 128'(2'b10));
  endtask

  typedef struct {
    bit           wr;
    logic [7:0]   a;
    logic [127:0] d;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [127:0] pat_a5;
  logic [127:0] pat_x;
  logic [127:0] exp;

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
    pat_a5 = {16{8'hA5}};
    pat_x  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vecs[0] = '{1'b0, 8'h20, '0, 0, seqblk(8'h20)};
    vecs[1] = '{1'b0, 8'h27, '0, 2, seqblk(8'h20)};
    vecs[2] = '{1'b1, 8'h40, pat_a5, 0, WR_EN ? pat_a5 : seqblk(8'h40)};
    vecs[3] = '{1'b0, 8'h40, '0, 10, WR_EN ? pat_a5 : seqblk(8'h40)};
    vecs[4] = '{1'b0, 8'h00, '0, 1, seqblk(8'h00)};
    vecs[5] = '{1'b0, 8'hFF, '0, 0, seqblk(8'hF0)};
    vecs[6] = '{1'b1, 8'hC3, pat_x, 3, WR_EN ? pat_x : seqblk(8'hC0)};
    vecs[7] = '{1'b0, 8'hC0, '0, 0, WR_EN ? pat_x : seqblk(8'hC0)};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; addr = '0; wdata = '0;
    resp_ready = 1'b0;
    req_valid0 = 1'b0; req_write0 = 1'b0; addr0 = '0; wdata0 = '0;
    resp_ready0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset ready", 128'(req_ready), 128'(1));
    check("reset resp_valid", 128'(resp_valid), 128'(0));
    check("reset rdata", rdata, '0);

    for (int v = 0; v < 8; v++) begin
      exp = model_access(vecs[v].wr, vecs[v].a, vecs[v].d);
      check($sformatf("vec%0d model", v), vecs[v].exp, exp);
      access($sformatf("vec%0d", v), vecs[v].wr, vecs[v].a,
             vecs[v].d, vecs[v].hold, vecs[v].exp);
    end

    begin : abort_write
      bit seen;
      req_valid = 1'b1; req_write = 1'b1; addr = 8'h80;
      wdata = {16{8'h3C}};
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort ready", 128'(req_ready), 128'(1));
      check("abort rdata", rdata, '0);
      seen = 1'b0;
      repeat (30) begin
        @(posedge clk); #1;
        if (resp_valid) seen = 1'b1;
      end
      check("abort no resp", 128'(seen), 128'(0));
      if (WR_EN) for (int i = 0; i < 5; i++) mem_m[8'h80 + i] = 8'h3C;
      exp = seqblk(8'h80);
      if (WR_EN) exp[39:0] = {5{8'h3C}};
      access("abort readback", 1'b0, 8'h80, '0, 0, exp);
    end

    begin : zero_latency
      int cyc;
      req_valid0 = 1'b1; addr0 = 8'hF0;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      cyc = 1;
      while (!resp_valid0 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("lat0 latency", 128'(cyc), 128'(17));
      check("lat0 data", rdata0, seqblk(8'hF0));
      resp_ready0 = 1'b1;
      @(posedge clk); #1;
      resp_ready0 = 1'b0;
      check("lat0 release", 128'({req_ready0, resp_valid0}), 128'(2'b10));
    end

    for (int n = 0; n < 40; n++) begin
      bit w;
      logic [7:0] a;
      logic [127:0] d;
      int hold;
      w = 1'($urandom);
      a = 8'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      hold = $urandom_range(0, 3);
      exp = model_access(w, a, d);
      access($sformatf("rnd%0d", n), w, a, d, hold, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
